// File: rtl/render_pkg.sv
// Shared types for the render command sequencer: register map, command record, FSM states.
// Helper functions map a write state to the render slave's address and data word.
package render_pkg;

   localparam logic [3:0] REG_X    = 4'd1;
   localparam logic [3:0] REG_Y    = 4'd2;
   localparam logic [3:0] REG_TEX  = 4'd4;
   localparam logic [3:0] REG_PLOT = 4'd6;

   typedef enum logic {
      SPRITE = 1'b0,
      FILL   = 1'b1
   } cmd_kind_e;

   typedef struct packed {
      cmd_kind_e  kind;
      logic [6:0] texture;
      logic [8:0] x;
      logic [7:0] y;
   } render_cmd_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_TEX  = 3'd1,
      WR_X    = 3'd2,
      WR_Y    = 3'd3,
      WR_PLOT = 3'd4
   } seq_state_e;

   function automatic logic [3:0] reg_addr(input seq_state_e s);
      logic [3:0] a;
      case (s)
         WR_TEX:  a = REG_TEX;
         WR_X:    a = REG_X;
         WR_Y:    a = REG_Y;
         WR_PLOT: a = REG_PLOT;
         default: a = 4'd0;
      endcase
      return a;
   endfunction

   function automatic logic [31:0] reg_data(input seq_state_e s, input render_cmd_t c);
      logic [31:0] d;
      case (s)
         WR_TEX:  d = {25'b0, c.texture};
         WR_X:    d = {23'b0, c.x};
         WR_Y:    d = {24'b0, c.y};
         default: d = 32'd0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/render_cmd_fifo.sv
// First-word-fall-through command FIFO; head entry is visible on rd_data whenever !empty.
// Pushes while full and pops while empty are ignored.
module render_cmd_fifo
   import render_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  render_cmd_t              wr_data,
   input  logic                     pop,
   output render_cmd_t              rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   render_cmd_t   mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/render_cmd_sequencer.sv
// Replays queued draw commands as Avalon-MM write sequences to the render slave.
// Optional RENDER_SEQ_SKIP_REDUNDANT_EN: skip the texture write when it repeats the last one.
module render_cmd_sequencer
   import render_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_kind,
   input  logic [6:0]               cmd_texture,
   input  logic [8:0]               cmd_x,
   input  logic [7:0]               cmd_y,
   output logic [$clog2(DEPTH):0]   cmd_count,
   output logic                     busy,
   output logic [3:0]               m_address,
   output logic                     m_write,
   output logic [31:0]              m_writedata,
   input  logic                     m_waitrequest
);

   seq_state_e  state_q, state_d, nxt_state;
   render_cmd_t cmd_q, cmd_d;
   render_cmd_t in_cmd, fifo_head;
   logic        fifo_full, fifo_empty, fifo_pop;
   logic        m_write_q, m_write_d;
   logic [3:0]  m_address_q, m_address_d;
   logic [31:0] m_writedata_q, m_writedata_d;
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
   logic [6:0]  last_tex_q, last_tex_d;
   logic        last_tex_valid_q, last_tex_valid_d;
`endif

   assign in_cmd = '{kind: cmd_kind_e'(cmd_kind), texture: cmd_texture, x: cmd_x, y: cmd_y};

   render_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (cmd_valid && cmd_ready),
      .wr_data (in_cmd),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (cmd_count)
   );

   assign cmd_ready   = !fifo_full;
   assign busy        = !fifo_empty || (state_q != IDLE);
   assign m_write     = m_write_q;
   assign m_address   = m_address_q;
   assign m_writedata = m_writedata_q;

   always_comb begin
      case (state_q)
         WR_TEX:  nxt_state = (cmd_q.kind == SPRITE) ? WR_X : WR_PLOT;
         WR_X:    nxt_state = WR_Y;
         WR_Y:    nxt_state = WR_PLOT;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      fifo_pop      = 1'b0;
      m_write_d     = m_write_q;
      m_address_d   = m_address_q;
      m_writedata_d = m_writedata_q;
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
      last_tex_d       = last_tex_q;
      last_tex_valid_d = last_tex_valid_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cmd_d    = fifo_head;
               state_d  = WR_TEX;
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
               if (last_tex_valid_q && (fifo_head.texture == last_tex_q))
                  state_d = (fifo_head.kind == SPRITE) ? WR_X : WR_PLOT;
`endif
            end
         end
         WR_TEX, WR_X, WR_Y, WR_PLOT: begin
            // First cycle in a state only launches the write; later cycles wait for acceptance.
            if (!m_write_q) begin
               m_write_d     = 1'b1;
               m_address_d   = reg_addr(state_q);
               m_writedata_d = reg_data(state_q, cmd_q);
            end else if (!m_waitrequest) begin
               state_d = nxt_state;
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
               if (state_q == WR_TEX) begin
                  last_tex_d       = cmd_q.texture;
                  last_tex_valid_d = 1'b1;
               end
`endif
               if (state_q == WR_PLOT) begin
                  m_write_d = 1'b0;
               end else begin
                  m_address_d   = reg_addr(nxt_state);
                  m_writedata_d = reg_data(nxt_state, cmd_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         m_write_q     <= 1'b0;
         m_address_q   <= 4'd0;
         m_writedata_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         m_write_q     <= m_write_d;
         m_address_q   <= m_address_d;
         m_writedata_q <= m_writedata_d;
      end
   end

   always_ff @(posedge clk) begin
      cmd_q <= cmd_d;
   end

`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_tex_q       <= 7'd0;
         last_tex_valid_q <= 1'b0;
      end else begin
         last_tex_q       <= last_tex_d;
         last_tex_valid_q <= last_tex_valid_d;
      end
   end
`endif

endmodule

// File: tb/tb_render_cmd_sequencer.sv
// Bench for render_cmd_sequencer: directed scenarios plus random commands against a
// queue-based model of the expected bus write stream.
module tb_render_cmd_sequencer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_kind = 1'b0;
   logic [6:0]  cmd_texture = 7'd0;
   logic [8:0]  cmd_x = 9'd0;
   logic [7:0]  cmd_y = 8'd0;
   logic [3:0]  cmd_count;
   logic        busy;
   logic [3:0]  m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic        m_waitrequest = 1'b0;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int wait_mode = 0;
   int wcnt = 0;

   logic [35:0] exp_q[$];
   logic [6:0]  m_lt = 7'd0;
   logic        m_lt_v = 1'b0;

   logic        pw = 1'b0;
   logic [3:0]  pa = 4'd0;
   logic [31:0] pd = 32'd0;

   render_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_kind      (cmd_kind),
      .cmd_texture   (cmd_texture),
      .cmd_x         (cmd_x),
      .cmd_y         (cmd_y),
      .cmd_count     (cmd_count),
      .busy          (busy),
      .m_address     (m_address),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected write stream of one command, straight from the register map rules.
   task automatic expand(input logic k, input logic [6:0] t, input logic [8:0] px, input logic [7:0] py);
      logic skip;
      skip = 1'b0;
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
      if (m_lt_v && (m_lt == t)) skip = 1'b1;
      m_lt   = t;
      m_lt_v = 1'b1;
`endif
      if (!skip) exp_q.push_back({4'd4, 25'b0, t});
      if (k == 1'b0) begin
         exp_q.push_back({4'd1, 23'b0, px});
         exp_q.push_back({4'd2, 24'b0, py});
      end
      exp_q.push_back({4'd6, 32'd0});
   endtask

   // Waitrequest driver: 0 none, 1 three wait cycles per write, 2 random, 3 stuck high.
   always @(posedge clk) begin
      #1;
      case (wait_mode)
         1: begin
            if (m_write && wcnt == 3) begin
               m_waitrequest = 1'b0;
               wcnt = 0;
            end else if (m_write) begin
               m_waitrequest = 1'b1;
               wcnt++;
            end else begin
               m_waitrequest = 1'b1;
               wcnt = 0;
            end
         end
         2: m_waitrequest = ($urandom_range(0, 2) == 0);
         3: m_waitrequest = 1'b1;
         default: m_waitrequest = 1'b0;
      endcase
   end

   // Bus monitor: stability while stalled, and every accepted write against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         pw = 1'b0;
      end else begin
         if (pw) begin
            chk("hold_write", 64'(m_write), 64'd1);
            chk("hold_addr", 64'(m_address), 64'(pa));
            chk("hold_data", 64'(m_writedata), 64'(pd));
         end
         pw = m_write && m_waitrequest;
         pa = m_address;
         pd = m_writedata;
         if (m_write && !m_waitrequest) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("write_expected", 64'(exp_q.size()), 64'd1);
            else chk("write", 64'({m_address, m_writedata}), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic push_cmd(input logic k, input logic [6:0] t, input logic [8:0] px, input logic [7:0] py);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_kind = k;
      cmd_texture = t;
      cmd_x = px;
      cmd_y = py;
      @(negedge clk);
      while (!cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("push_timeout", 64'(cmd_ready), 64'd1);
      else expand(k, t, px, py);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("idle", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      m_lt_v = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, acc, n;
      // Reset state, held through idle cycles.
      @(negedge clk);
      chk("rst_write", 64'(m_write), 64'd0);
      chk("rst_count", 64'(cmd_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_addr", 64'(m_address), 64'd0);
      chk("rst_data", 64'(m_writedata), 64'd0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_write", 64'(m_write), 64'd0);
         chk("idle_ready", 64'(cmd_ready), 64'd1);
         chk("idle_busy", 64'(busy), 64'd0);
         chk("idle_count", 64'(cmd_count), 64'd0);
      end
      @(posedge clk);
      #1;

      // SPRITE, no wait states: latency and four consecutive writes.
      wait_mode = 0;
      c0 = wr_cnt;
      push_cmd(1'b0, 7'h05, 9'd159, 8'd119);
      chk("lat_k0", 64'(m_write), 64'd0);
      @(posedge clk); #1;
      chk("lat_k1", 64'(m_write), 64'd0);
      @(posedge clk); #1;
      chk("lat_k2", 64'({m_write, m_address}), 64'h14);
      @(posedge clk); #1;
      chk("seq_x", 64'({m_write, m_address}), 64'h11);
      @(posedge clk); #1;
      chk("seq_y", 64'({m_write, m_address}), 64'h12);
      @(posedge clk); #1;
      chk("seq_plot", 64'({m_write, m_address}), 64'h16);
      @(posedge clk); #1;
      chk("seq_done", 64'(m_write), 64'd0);
      wait_idle(50);
      chk("sprite_writes", 64'(wr_cnt - c0), 64'd4);

      // FILL with three wait cycles on every write.
      wait_mode = 1;
      c0 = wr_cnt;
      push_cmd(1'b1, 7'h6A, 9'd3, 8'd4);
      wait_idle(200);
      chk("fill_writes", 64'(wr_cnt - c0), 64'd2);

      // Slave stalled: fill the FIFO behind one in-flight command.
      wait_mode = 3;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         cmd_valid = 1'b1;
         cmd_kind = 1'($urandom_range(0, 1));
         cmd_texture = 7'(i + 16);
         cmd_x = 9'($urandom_range(0, 511));
         cmd_y = 8'($urandom_range(0, 255));
         @(negedge clk);
         if (cmd_ready) begin
            acc++;
            expand(cmd_kind, cmd_texture, cmd_x, cmd_y);
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      chk("full_accepted", 64'(acc), 64'd9);
      chk("full_count", 64'(cmd_count), 64'd8);
      chk("full_ready", 64'(cmd_ready), 64'd0);
      chk("full_busy", 64'(busy), 64'd1);
      wait_mode = 0;
      wait_idle(500);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of WR_Y with a second command queued.
      push_cmd(1'b0, 7'h11, 9'd300, 8'd200);
      push_cmd(1'b0, 7'h22, 9'd10, 8'd20);
      n = 0;
      @(negedge clk);
      while (!(m_write && m_address == 4'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wr_y", 64'(m_address), 64'd2);
      #2;
      rst_n = 1'b0;
      m_lt_v = 1'b0;
      #1;
      chk("mid_rst_write", 64'(m_write), 64'd0);
      chk("mid_rst_count", 64'(cmd_count), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      c0 = wr_cnt;
      push_cmd(1'b0, 7'h11, 9'd1, 8'd2);
      wait_idle(100);
      chk("post_rst_writes", 64'(wr_cnt - c0), 64'd4);

      // Two SPRITEs with the same texture after reset.
      do_reset();
      c0 = wr_cnt;
      push_cmd(1'b0, 7'h01, 9'd5, 8'd6);
      push_cmd(1'b0, 7'h01, 9'd7, 8'd8);
      wait_idle(200);
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
      chk("same_tex_writes", 64'(wr_cnt - c0), 64'd7);
`else
      chk("same_tex_writes", 64'(wr_cnt - c0), 64'd8);
`endif

      // Random commands under random wait states, including off-screen coordinates.
      wait_mode = 2;
      for (int i = 0; i < 60; i++) begin
         push_cmd(1'($urandom_range(0, 1)), 7'($urandom_range(0, 3)),
                  9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_idle(5000);
      chk("random_drain", 64'(exp_q.size()), 64'd0);
      chk("random_count", 64'(cmd_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
